ysyx_25040111_imem_resp: RTL

Instruction-fetch responder for the single-outstanding fetch handshake (`if_start` pulse in, `if_ok` pulse plus `inst_t` word out). It sits between the fetch unit and a synchronous-read instruction SRAM. It captures the fetch PC and inserts a programmable, optionally pseudo-random delay to stress the fetch path. It then performs one SRAM read and returns the word or an alignment fault.

---
 rtl/ysyx_25040111_imem_resp_pkg.sv | 18 +
 rtl/ysyx_25040111_imem_resp_if.sv | 25 ++
 rtl/ysyx_25040111_lfsr16.sv | 20 ++
 rtl/ysyx_25040111_imem_resp.sv | 89 ++++++++
 4 files changed

// File: rtl/ysyx_25040111_imem_resp_pkg.sv
// Shared definitions for the instruction-fetch responder and its latency-injection helpers.
package ysyx_25040111_imem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/ysyx_25040111_imem_resp_if.sv
// Fetch handshake plus instruction-SRAM read port; slave is the responder side.
interface ysyx_25040111_imem_resp_if;

    logic        if_start;
    logic [31:0] pc;
    logic [31:0] inst_t;
    logic        if_ok;
    logic        fault;
    logic        busy;
    logic        drop_err;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_start, pc, mem_rdata,
        output inst_t, if_ok, fault, busy, drop_err, mem_en, mem_addr
    );

    modport master (
        output if_start, pc, mem_rdata,
        input  inst_t, if_ok, fault, busy, drop_err, mem_en, mem_addr
    );

endinterface

// File: rtl/ysyx_25040111_lfsr16.sv
// Free-running 16-bit Galois LFSR used to jitter responder latencies.
module ysyx_25040111_lfsr16
    import ysyx_25040111_imem_resp_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/ysyx_25040111_imem_resp.sv
// Single-outstanding instruction-fetch responder with programmable/jittered delay before one SRAM read.
module ysyx_25040111_imem_resp
    import ysyx_25040111_imem_resp_pkg::*;
#(
    parameter int unsigned LAT     = 0,
    parameter int unsigned RAND_EN = 0,
    parameter int unsigned JIT_W   = 2,
    parameter logic [15:0] SEED    = DEFAULT_SEED
) (
    input  logic                          clk,
    input  logic                          reset,
    ysyx_25040111_imem_resp_if.slave      bus
);

    localparam logic [15:0] JIT_MASK = (RAND_EN != 0) ? 16'((1 << JIT_W) - 1) : 16'h0000;

    state_e      r_state;
    logic [8:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_ok;
    logic        r_fault;
    logic        r_drop;

    logic [15:0] w_lfsr;
    logic [8:0]  w_load;
    logic        w_mis;

    ysyx_25040111_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    assign w_load = 9'(LAT) + 9'(w_lfsr & JIT_MASK);
    assign w_mis  = (r_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_ok    <= 1'b0;
            r_fault <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_ok    <= 1'b0;
            r_fault <= 1'b0;
            if (bus.if_start && r_state != IDLE) begin
                r_drop <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.if_start) begin
                        r_pc    <= bus.pc;
                        r_cnt   <= w_load;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_inst  <= w_mis ? 32'h0 : bus.mem_rdata;
                    r_ok    <= 1'b1;
                    r_fault <= w_mis;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.inst_t   = r_inst;
    assign bus.if_ok    = r_ok;
    assign bus.fault    = r_fault;
    assign bus.busy     = (r_state != IDLE);
    assign bus.drop_err = r_drop;
    assign bus.mem_en   = (r_state == WAIT) && (r_cnt == '0) && !w_mis;
    assign bus.mem_addr = r_pc[31:2];

endmodule
